// File: rtl/reg_bus_pkg.sv
// Shared FSM encoding and register map for the register bus master and its responders.
package reg_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    RWAIT  = 3'd4,
    VERIFY = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam logic [7:0] REG_TRACE   = 8'h00;
  localparam logic [7:0] REG_VERSION = 8'h01;
  localparam logic [7:0] REG_SCRATCH = 8'h42;
  localparam int         TRACE_LEN   = 8;

endpackage

// File: rtl/reg_bus_rd_pipe.sv
// Read-latency delay line: delays the reg_read strobe by pREAD_LATENCY cycles so the
// master knows exactly when read_data from the responder is valid.
module reg_bus_rd_pipe #(
  parameter int pREAD_LATENCY = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic strobe_i,
  output logic valid_o
);

  logic [pREAD_LATENCY-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= strobe_i;
      for (int i = 1; i < pREAD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[pREAD_LATENCY-1];

endmodule

// File: rtl/reg_bus_master.sv
// Command-driven register bus master: turns read/write burst commands into reg_* strobes.
// Optional write read-back check is compiled in with REG_MASTER_WRVERIFY_EN.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_LATENCY = 1
) (
  input  logic                     usb_clk,
  input  logic                     reset_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic                     cmd_verify,
  input  logic [7:0]               cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic                     done,
  output logic                     verify_err,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic                     reg_addrvalid,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic [7:0]               write_data,
  input  logic [7:0]               read_data
);

  state_e                   state_q;
  logic                     cmdReady_q;
  logic                     wrReady_q;
  logic                     rdValid_q;
  logic [7:0]               rdData_q;
  logic                     done_q;
  logic                     addrValid_q;
  logic [7:0]               address_q;
  logic [pBYTECNT_SIZE-1:0] bytecnt_q;
  logic [pBYTECNT_SIZE-1:0] lastIdx_q;
  logic                     read_q;
  logic                     write_q;
  logic                     verify_q;
  logic                     pipeValid;
  logic                     verifyReq;
  logic                     lastByte;

  reg_bus_rd_pipe #(
    .pREAD_LATENCY(pREAD_LATENCY)
  ) u_rd_pipe (
    .clk_i   (usb_clk),
    .reset_i (reset_i),
    .strobe_i(read_q),
    .valid_o (pipeValid)
  );

  assign lastByte = (bytecnt_q == lastIdx_q);

`ifdef REG_MASTER_WRVERIFY_EN
  logic [7:0] wrCopy_q [0:(1<<pBYTECNT_SIZE)-1];
  logic       verifyErr_q;

  assign verifyReq = cmd_verify;

  always_ff @(posedge usb_clk) begin
    if (reg_write) begin
      wrCopy_q[bytecnt_q] <= wr_data;
    end
  end

  // Sticky across commands; only reset or the next accepted verify command clears it.
  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      verifyErr_q <= 1'b0;
    end else if (cmd_valid && cmdReady_q && cmd_verify) begin
      verifyErr_q <= 1'b0;
    end else if (state_q == RWAIT && write_q && pipeValid &&
                 read_data != wrCopy_q[bytecnt_q]) begin
      verifyErr_q <= 1'b1;
    end
  end

  assign verify_err = verifyErr_q;
`else
  logic unusedVerify;

  assign verifyReq    = 1'b0;
  assign unusedVerify = cmd_verify;
  assign verify_err   = 1'b0;
`endif

  // A read in RWAIT belongs to a verify pass when the command was a write.
  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cmdReady_q  <= 1'b1;
      wrReady_q   <= 1'b0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      done_q      <= 1'b0;
      addrValid_q <= 1'b0;
      address_q   <= '0;
      bytecnt_q   <= '0;
      lastIdx_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      verify_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && cmdReady_q) begin
            cmdReady_q <= 1'b0;
            write_q    <= cmd_write;
            verify_q   <= verifyReq & cmd_write;
            lastIdx_q  <= cmd_len - 1'b1;
            address_q  <= cmd_addr;
            bytecnt_q  <= '0;
            if (cmd_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= SETUP;
              addrValid_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (write_q) begin
            state_q   <= WRITE;
            wrReady_q <= 1'b1;
          end else begin
            state_q <= READ;
            read_q  <= 1'b1;
          end
        end
        WRITE: begin
          if (reg_write) begin
            if (lastByte) begin
              wrReady_q <= 1'b0;
              if (verify_q) begin
                state_q   <= VERIFY;
                bytecnt_q <= '0;
                read_q    <= 1'b1;
              end else begin
                state_q     <= DONE;
                done_q      <= 1'b1;
                addrValid_q <= 1'b0;
              end
            end else begin
              bytecnt_q <= bytecnt_q + 1'b1;
            end
          end
        end
        READ: begin
          if (read_q) begin
            read_q  <= 1'b0;
            state_q <= RWAIT;
          end else if (rd_ready) begin
            rdValid_q <= 1'b0;
            if (lastByte) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              addrValid_q <= 1'b0;
            end else begin
              bytecnt_q <= bytecnt_q + 1'b1;
              read_q    <= 1'b1;
            end
          end
        end
        VERIFY: begin
          read_q  <= 1'b0;
          state_q <= RWAIT;
        end
        RWAIT: begin
          if (pipeValid) begin
            if (write_q) begin
              if (lastByte) begin
                state_q     <= DONE;
                done_q      <= 1'b1;
                addrValid_q <= 1'b0;
              end else begin
                state_q   <= VERIFY;
                bytecnt_q <= bytecnt_q + 1'b1;
                read_q    <= 1'b1;
              end
            end else begin
              rdData_q  <= read_data;
              rdValid_q <= 1'b1;
              state_q   <= READ;
            end
          end
        end
        DONE: begin
          addrValid_q <= 1'b0;
          cmdReady_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = cmdReady_q;
  assign wr_ready      = wrReady_q;
  assign rd_valid      = rdValid_q;
  assign rd_data       = rdData_q;
  assign done          = done_q;
  assign reg_address   = address_q;
  assign reg_bytecnt   = bytecnt_q;
  assign reg_addrvalid = addrValid_q;
  assign reg_read      = read_q;
  assign reg_write     = wrReady_q & wr_valid;
  assign write_data    = wr_data;

endmodule
